// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS fetch path: start arming, stall, redirect, halt, end-of-program.
// Optional jump-and-link support (link register, i_jal/i_jr) is enabled by defining PC_SEQ_LINK_EN.
module pc_sequencer #(
   parameter int PC_W     = 9,
   parameter int RESET_PC = 0,
   parameter int PC_MAX   = 511,
   parameter int WRAP_EN  = 0
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [PC_W-1:0] i_target,
   input  logic            i_jal,
   input  logic            i_jr,
   input  logic            i_halt,
   output logic [PC_W-1:0] o_pc,
   output logic            o_fetch_valid,
   output logic            o_flush,
   output logic [1:0]      o_state,
   output logic            o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] LP_RESET_PC = RESET_PC[PC_W-1:0];
   localparam logic [PC_W-1:0] LP_PC_MAX   = PC_MAX[PC_W-1:0];
   localparam logic [PC_W-1:0] LP_ONE      = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          r_state, w_next_state;
   logic [PC_W-1:0] r_pc, w_next_pc, w_pc_inc;
   logic            r_flush, w_next_flush;

`ifdef PC_SEQ_LINK_EN
   logic [PC_W-1:0] r_link, w_next_link;
`else
   logic            w_unused_jr;
   assign w_unused_jr = i_jr;
`endif

   assign w_pc_inc = r_pc + LP_ONE;

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_flush = 1'b0;
`ifdef PC_SEQ_LINK_EN
      w_next_link  = r_link;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next_state = S_ARM;
         end
         S_ARM: begin
            w_next_state = S_RUN;
         end
         S_RUN: begin
            if (i_halt) begin
               w_next_state = S_HALT;
            end
`ifdef PC_SEQ_LINK_EN
            else if (i_jr) begin
               w_next_pc    = r_link;
               w_next_flush = 1'b1;
            end
`endif
            else if (i_redirect || i_jal) begin
               w_next_pc    = i_target;
               w_next_flush = 1'b1;
`ifdef PC_SEQ_LINK_EN
               if (i_jal) w_next_link = w_pc_inc;
`endif
            end
            else if (i_stall) begin
               w_next_pc = r_pc;
            end
            // A PC loaded above PC_MAX counts as already past the end.
            else if (r_pc >= LP_PC_MAX) begin
               if (WRAP_EN != 0) w_next_pc = LP_RESET_PC;
               else              w_next_state = S_HALT;
            end
            else begin
               w_next_pc = w_pc_inc;
            end
         end
         S_HALT: begin
            if (i_start) begin
               w_next_pc    = LP_RESET_PC;
               w_next_state = S_ARM;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= LP_RESET_PC;
         r_flush <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         r_flush <= w_next_flush;
      end
   end

`ifdef PC_SEQ_LINK_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_link <= LP_RESET_PC;
      else          r_link <= w_next_link;
   end
`endif

   assign o_pc          = r_pc;
   assign o_flush       = r_flush;
   assign o_state       = r_state;
   assign o_done        = (r_state == S_HALT);
   assign o_fetch_valid = (r_state == S_RUN) && !i_stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, plus wrap-around and asynchronous-reset sequences.
module tb_pc_sequencer;

   logic       clk, rst_n;
   logic       start, stall, redir, jal, jr, halt;
   logic [8:0] tgt;
   logic [8:0] pc;
   logic       fv, fl, dn;
   logic [1:0] st;

   logic       w_start, w_redir;
   logic [8:0] w_tgt;
   logic [8:0] w_pc;
   logic       w_fv, w_fl, w_dn;
   logic [1:0] w_st;

   int n_checks = 0;
   int n_fail   = 0;

   pc_sequencer u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall),
      .i_redirect(redir), .i_target(tgt), .i_jal(jal), .i_jr(jr), .i_halt(halt),
      .o_pc(pc), .o_fetch_valid(fv), .o_flush(fl), .o_state(st), .o_done(dn)
   );

   pc_sequencer #(.PC_W(9), .RESET_PC(0), .PC_MAX(10), .WRAP_EN(1)) u_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(w_start), .i_stall(1'b0),
      .i_redirect(w_redir), .i_target(w_tgt), .i_jal(1'b0), .i_jr(1'b0), .i_halt(1'b0),
      .o_pc(w_pc), .o_fetch_valid(w_fv), .o_flush(w_fl), .o_state(w_st), .o_done(w_dn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start, stall, redir, jal, jr, halt;
      logic [8:0] tgt;
      logic [8:0] e_pc;
      logic       e_fv, e_fl, e_dn;
      logic [1:0] e_st;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic sl, input logic r, input logic j, input logic jrr,
                      input logic h, input logic [8:0] t, input logic [8:0] ep, input logic [1:0] es,
                      input logic efv, input logic efl, input logic edn);
      vec_t v;
      v.start = s; v.stall = sl; v.redir = r; v.jal = j; v.jr = jrr; v.halt = h; v.tgt = t;
      v.e_pc = ep; v.e_st = es; v.e_fv = efv; v.e_fl = efl; v.e_dn = edn;
      vq.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 0; stall = 0; redir = 0; jal = 0; jr = 0; halt = 0; tgt = '0;
      w_start = 0; w_redir = 0; w_tgt = '0;

      //   start stall redir jal jr halt tgt      pc      st  fv fl dn
      add(1, 0, 0, 0, 0, 0, 9'd0,   9'd0,   2'd1, 0, 0, 0); // ARM
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd0,   2'd2, 1, 0, 0); // first fetch pc 0
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd1,   2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd2,   2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd3,   2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd4,   2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd5,   2'd2, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0, 9'd0,   9'd5,   2'd2, 0, 0, 0); // stall x3
      add(0, 1, 0, 0, 0, 0, 9'd0,   9'd5,   2'd2, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 9'd0,   9'd5,   2'd2, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd6,   2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd7,   2'd2, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0, 9'h040, 9'h040, 2'd2, 0, 1, 0); // redirect beats stall
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'h041, 2'd2, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 9'h050, 9'h050, 2'd2, 1, 1, 0); // back-to-back redirects
      add(0, 0, 1, 0, 0, 0, 9'h060, 9'h060, 2'd2, 1, 1, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'h061, 2'd2, 1, 0, 0);
      add(0, 0, 1, 0, 0, 1, 9'h010, 9'h061, 2'd3, 0, 0, 1); // halt beats redirect
      add(0, 1, 1, 1, 1, 1, 9'h020, 9'h061, 2'd3, 0, 0, 1); // HALT ignores all but start
      add(1, 0, 0, 0, 0, 0, 9'd0,   9'd0,   2'd1, 0, 0, 0); // restart
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd0,   2'd2, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 9'd509, 9'd509, 2'd2, 1, 1, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd510, 2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd511, 2'd2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd511, 2'd3, 0, 0, 1); // end of program
      add(1, 0, 0, 0, 0, 0, 9'd0,   9'd0,   2'd1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd0,   2'd2, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 9'd20,  9'd20,  2'd2, 1, 1, 0);
      add(0, 0, 0, 1, 0, 0, 9'd100, 9'd100, 2'd2, 1, 1, 0); // jal
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd101, 2'd2, 1, 0, 0);
`ifdef PC_SEQ_LINK_EN
      add(0, 0, 0, 0, 1, 0, 9'd0,   9'd21,  2'd2, 1, 1, 0); // jr returns to link
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd22,  2'd2, 1, 0, 0);
`else
      add(0, 0, 0, 0, 1, 0, 9'd0,   9'd102, 2'd2, 1, 0, 0); // jr ignored
      add(0, 0, 0, 0, 0, 0, 9'd0,   9'd103, 2'd2, 1, 0, 0);
`endif
      add(0, 0, 1, 0, 0, 0, 9'd33,  9'd33,  2'd2, 1, 1, 0);

      step(); step();
      rst_n = 1'b1;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_state", 32'(st), 32'd0);
      chk("rst_fv", 32'(fv), 32'd0);
      chk("rst_flush", 32'(fl), 32'd0);
      chk("rst_done", 32'(dn), 32'd0);
      chk("rst_wrap_pc", 32'(w_pc), 32'd0);

      foreach (vq[i]) begin
         start = vq[i].start; stall = vq[i].stall; redir = vq[i].redir;
         jal = vq[i].jal; jr = vq[i].jr; halt = vq[i].halt; tgt = vq[i].tgt;
         step();
         chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vq[i].e_pc));
         chk($sformatf("v%0d_state", i), 32'(st), 32'(vq[i].e_st));
         chk($sformatf("v%0d_fv", i), 32'(fv), 32'(vq[i].e_fv));
         chk($sformatf("v%0d_flush", i), 32'(fl), 32'(vq[i].e_fl));
         chk($sformatf("v%0d_done", i), 32'(dn), 32'(vq[i].e_dn));
      end
      start = 0; stall = 0; redir = 0; jal = 0; jr = 0; halt = 0; tgt = '0;

      // Asynchronous reset mid-RUN at pc 33, away from any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", 32'(pc), 32'd0);
      chk("arst_state", 32'(st), 32'd0);
      chk("arst_fv", 32'(fv), 32'd0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk($sformatf("post_rst_fv%0d", k), 32'(fv), 32'd0);
         chk($sformatf("post_rst_state%0d", k), 32'(st), 32'd0);
      end

      // Wrap-enabled instance with PC_MAX=10.
      w_start = 1; step();
      w_start = 0;
      chk("wrap_arm", 32'(w_st), 32'd1);
      step();
      chk("wrap_run_pc", 32'(w_pc), 32'd0);
      repeat (10) step();
      chk("wrap_at_max", 32'(w_pc), 32'd10);
      step();
      chk("wrap_to_reset", 32'(w_pc), 32'd0);
      chk("wrap_state", 32'(w_st), 32'd2);
      chk("wrap_fv", 32'(w_fv), 32'd1);
      w_redir = 1; w_tgt = 9'd20; step();
      w_redir = 0;
      chk("wrap_over_pc", 32'(w_pc), 32'd20);
      chk("wrap_over_flush", 32'(w_fl), 32'd1);
      step();
      chk("wrap_over_next", 32'(w_pc), 32'd0);
      chk("wrap_done", 32'(w_dn), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the program counter for the single-cycle MIPS fetch path.
- Adds start arming, stall, branch/jump redirect, halt and end-of-program handling around the PC register.
- Sits between the control unit (stall/redirect/halt requests) and instruction memory (address plus fetch-valid).
- Drives the instruction-memory address port directly.

Parameters:
- PC_W, 9: PC width in bits (instruction-memory word address).
- RESET_PC, 0: PC value loaded on reset and on restart from HALT.
- PC_MAX, 511: last legal PC. Must satisfy RESET_PC <= PC_MAX <= 2^PC_W-1.
- WRAP_EN, 0: 1 = increment past PC_MAX wraps to RESET_PC; 0 = reaching PC_MAX and incrementing enters HALT.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  level or pulse; arms fetch from IDLE or HALT.
- i_stall  input  1  hold PC this cycle (pipeline/memory not ready).
- i_redirect  input  1  branch-taken or jump; load i_target.
- i_target  input  PC_W  redirect destination.
- i_jal  input  1  jump-and-link (see Optional Feature).
- i_jr  input  1  jump to link register (see Optional Feature).
- i_halt  input  1  halt instruction decoded at current PC.
- o_pc  output  PC_W  current fetch address.
- o_fetch_valid  output  1  o_pc is a real fetch this cycle.
- o_flush  output  1  one-cycle pulse the cycle after a redirect.
- o_state  output  2  IDLE=0, ARM=1, RUN=2, HALT=3.
- o_done  output  1  high while in HALT.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, o_pc=RESET_PC.
  - o_fetch_valid=0, o_flush=0, o_done=0, link=RESET_PC.
- Outputs are registered. o_fetch_valid is combinational from state and i_stall: it is 1 only in RUN with i_stall=0.
- IDLE: PC holds. i_start=1 -> ARM next cycle. All other inputs are ignored.
- ARM: exactly one cycle, PC held, fetch_valid=0. Always -> RUN. This is a one-cycle start latency, so the first valid fetch occurs 2 cycles after i_start is sampled.
- RUN: each edge evaluates, highest priority first:
  1. i_halt: -> HALT, PC held.
  2. i_jr: see Optional Feature.
  3. i_redirect or i_jal: o_pc<=i_target, o_flush<=1 next cycle.
  4. i_stall: PC held.
  5. Increment:
     - If o_pc==PC_MAX: WRAP_EN=1 -> o_pc<=RESET_PC, stay RUN; WRAP_EN=0 -> HALT, PC held at PC_MAX.
     - Else o_pc<=o_pc+1, with the sum truncated to PC_W.
- Redirect overrides stall in the same cycle. Halt overrides redirect.
- i_target > PC_MAX: loaded as-is. The bound check applies only on the next increment; a loaded PC above PC_MAX is treated as at/after PC_MAX, giving wrap or halt.
- HALT: PC held, o_done=1. i_start=1 -> o_pc<=RESET_PC, -> ARM. All other inputs are ignored.
- o_flush is high for exactly one cycle per accepted redirect. Back-to-back redirects give continuous o_flush.
- Reset mid-RUN or mid-ARM: returns to IDLE immediately. No fetch_valid glitch after deassertion.

Optional Feature:
- Macro: PC_SEQ_LINK_EN.
- Defined:
  - Internal PC_W link register.
  - Accepted i_jal (RUN, not halted) stores o_pc+1 (truncated) into link and jumps to i_target.
  - i_jr in RUN loads o_pc<=link and pulses o_flush. i_jr has priority over i_redirect/i_jal.
- Undefined:
  - No link register.
  - i_jal behaves exactly as i_redirect.
  - i_jr is ignored.

Test Plan:
- Reset, then i_start pulse at cycle 0 -> ARM at cycle 1; o_fetch_valid=1 with o_pc=0 at cycle 2; o_pc=1,2,3 on cycles 3,4,5.
- RUN at o_pc=5, i_stall high 3 cycles -> o_pc stays 5 and fetch_valid=0 for those cycles; o_pc=6 on the first cycle after release.
- o_pc=7, i_stall=1 and i_redirect=1 with i_target=0x040 together -> o_pc=0x040 next cycle, o_flush=1 for one cycle; i_halt asserted together with a redirect -> HALT, PC unchanged.
- PC_MAX=10: with WRAP_EN=0, incrementing at o_pc=10 -> HALT, o_done=1, o_pc=10; with WRAP_EN=1 -> o_pc=0. From HALT, i_start -> o_pc=0, ARM, then RUN.
- PC_SEQ_LINK_EN defined: i_jal at o_pc=20, target=100 -> o_pc=100; later i_jr -> o_pc=21 with o_flush. Undefined: i_jr ignored, o_pc increments.
- i_rst_n low asynchronously mid-RUN at o_pc=33 -> o_pc=0, state IDLE, fetch_valid=0 immediately.
